// File: rtl/id_queue_dp_pkg.sv
// id_queue_dp_pkg
//   Sizing helpers shared by the dual-port ID queue, its bus interface and its
//   head-tail matcher: index widths, the occupancy-count width and the derived
//   number of head-tail entries.
//   Ports: none (package).
package id_queue_dp_pkg;

  // Width of an index into an n-entry table; one bit even for tiny tables.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must represent 0..cap inclusive.
  function automatic int unsigned cnt_w(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

  // There can never be more live IDs than distinct ID values or stored elements.
  function automatic int unsigned ht_cap(input int unsigned id_w, input int unsigned cap);
    return ((32'd1 << id_w) < cap) ? (32'd1 << id_w) : cap;
  endfunction

endpackage

// File: rtl/id_queue_dp_if.sv
// id_queue_dp_if
//   Bundles the push, pop/read, exists-search and status signals of the
//   dual-port ID queue.
//   Push:    inp_id_i, inp_data_i, inp_req_i -> inp_gnt_o
//   Pop:     oup_id_i, oup_pop_i, oup_req_i -> oup_data_o, oup_data_valid_o, oup_gnt_o
//   Exists:  exists_data_i, exists_mask_i, exists_req_i -> exists_o, exists_gnt_o
//   Status:  count_o, full_o, empty_o
//   Modports: master (requester side), slave (queue side).
interface id_queue_dp_if import id_queue_dp_pkg::*; #(
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CAPACITY   = 8
);
  localparam int unsigned CNT_W = cnt_w(CAPACITY);

  logic [ID_WIDTH-1:0]   inp_id_i;
  logic [DATA_WIDTH-1:0] inp_data_i;
  logic                  inp_req_i;
  logic                  inp_gnt_o;
  logic [ID_WIDTH-1:0]   oup_id_i;
  logic                  oup_pop_i;
  logic                  oup_req_i;
  logic [DATA_WIDTH-1:0] oup_data_o;
  logic                  oup_data_valid_o;
  logic                  oup_gnt_o;
  logic [DATA_WIDTH-1:0] exists_data_i;
  logic [DATA_WIDTH-1:0] exists_mask_i;
  logic                  exists_req_i;
  logic                  exists_o;
  logic                  exists_gnt_o;
  logic [CNT_W-1:0]      count_o;
  logic                  full_o;
  logic                  empty_o;

  modport master (
    output inp_id_i, inp_data_i, inp_req_i, oup_id_i, oup_pop_i, oup_req_i,
           exists_data_i, exists_mask_i, exists_req_i,
    input  inp_gnt_o, oup_data_o, oup_data_valid_o, oup_gnt_o, exists_o,
           exists_gnt_o, count_o, full_o, empty_o
  );

  modport slave (
    input  inp_id_i, inp_data_i, inp_req_i, oup_id_i, oup_pop_i, oup_req_i,
           exists_data_i, exists_mask_i, exists_req_i,
    output inp_gnt_o, oup_data_o, oup_data_valid_o, oup_gnt_o, exists_o,
           exists_gnt_o, count_o, full_o, empty_o
  );

endinterface

// File: rtl/id_queue_dp_ht_match.sv
// id_queue_dp_ht_match
//   Combinational CAM lookup over the head-tail table: reports whether an
//   allocated entry holds id_i and, if so, its index.
//   ids_i   in   per-entry ID
//   free_i  in   per-entry free flag (free entries never match)
//   id_i    in   ID to look up
//   match_o out  an allocated entry holds id_i
//   idx_o   out  index of that entry ('0 when no match)
module id_queue_dp_ht_match import id_queue_dp_pkg::*; #(
  parameter  int unsigned ID_WIDTH    = 2,
  parameter  int unsigned HT_CAPACITY = 4,
  localparam int unsigned HT_IDX_W    = idx_w(HT_CAPACITY)
) (
  input  logic [HT_CAPACITY-1:0][ID_WIDTH-1:0] ids_i,
  input  logic [HT_CAPACITY-1:0]               free_i,
  input  logic [ID_WIDTH-1:0]                  id_i,
  output logic                                 match_o,
  output logic [HT_IDX_W-1:0]                  idx_o
);

  // An ID owns at most one allocated entry, so at most one hit is possible.
  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < int'(HT_CAPACITY); i++) begin
      if (!free_i[i] && (ids_i[i] == id_i)) begin
        match_o = 1'b1;
        idx_o   = HT_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/id_queue_dp.sv
// id_queue_dp
//   Dual-port ID queue: elements tagged with an ID share CAPACITY slots, FIFO
//   order is kept per ID via a head-tail table plus a linked data table. Push
//   and pop/read are serviced in the same cycle; an exists search scans all
//   stored elements under a mask.
//   clk_i  in  clock, rising edge
//   rst_i  in  synchronous active-high reset (clears free bits and count only)
//   bus    id_queue_dp_if.slave: push, pop/read, exists and status signals
//   Optional build macro ID_QUEUE_DP_BYPASS_EN: a pop/read of an ID absent
//   before the cycle, concurrent with a granted push of that ID, returns the
//   pushed data; a pop then consumes it without storing it.
module id_queue_dp import id_queue_dp_pkg::*; #(
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned CAPACITY   = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  id_queue_dp_if.slave bus
);
  localparam int unsigned HT_CAPACITY = ht_cap(ID_WIDTH, CAPACITY);
  localparam int unsigned IDX_W       = idx_w(CAPACITY);
  localparam int unsigned HT_IDX_W    = idx_w(HT_CAPACITY);
  localparam int unsigned CNT_W       = cnt_w(CAPACITY);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [IDX_W-1:0]    head;
    logic [IDX_W-1:0]    tail;
    logic                free;
  } head_tail_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [IDX_W-1:0]      next;
    logic                  free;
  } linked_data_t;

  head_tail_t   ht_q [HT_CAPACITY];
  head_tail_t   ht_d [HT_CAPACITY];
  linked_data_t ld_q [CAPACITY];
  linked_data_t ld_d [CAPACITY];
  logic [CNT_W-1:0] count_q, count_d;

  logic [HT_CAPACITY-1:0][ID_WIDTH-1:0] ht_ids;
  logic [HT_CAPACITY-1:0]               ht_free;
  logic                full, push_gnt, push_store, push_hit, pop_hit, pop_rd, pop_eff, bypass_hit;
  logic [IDX_W-1:0]    free_slot, pop_head, push_tail;
  logic [HT_IDX_W-1:0] free_ht, pop_idx, push_idx;

  always_comb begin
    for (int i = 0; i < int'(HT_CAPACITY); i++) begin
      ht_ids[i]  = ht_q[i].id;
      ht_free[i] = ht_q[i].free;
    end
  end

  // Lowest free slot/entry from registered state only, so anything freed this
  // cycle is not reused before the next one.
  always_comb begin
    free_slot = '0;
    for (int i = int'(CAPACITY) - 1; i >= 0; i--) begin
      if (ld_q[i].free) free_slot = IDX_W'(i);
    end
    free_ht = '0;
    for (int i = int'(HT_CAPACITY) - 1; i >= 0; i--) begin
      if (ht_q[i].free) free_ht = HT_IDX_W'(i);
    end
  end

  id_queue_dp_ht_match #(.ID_WIDTH(ID_WIDTH), .HT_CAPACITY(HT_CAPACITY)) u_push_match (
    .ids_i(ht_ids), .free_i(ht_free), .id_i(bus.inp_id_i), .match_o(push_hit), .idx_o(push_idx)
  );

  id_queue_dp_ht_match #(.ID_WIDTH(ID_WIDTH), .HT_CAPACITY(HT_CAPACITY)) u_pop_match (
    .ids_i(ht_ids), .free_i(ht_free), .id_i(bus.oup_id_i), .match_o(pop_hit), .idx_o(pop_idx)
  );

  assign full             = (count_q == CNT_W'(CAPACITY));
  assign bus.full_o       = full;
  assign bus.empty_o      = (count_q == '0);
  assign bus.count_o      = count_q;
  assign bus.inp_gnt_o    = ~full;
  assign bus.oup_gnt_o    = bus.oup_req_i;
  assign bus.exists_gnt_o = bus.exists_req_i;

  assign push_gnt  = bus.inp_req_i & ~full;
  assign pop_head  = ht_q[pop_idx].head;
  assign push_tail = ht_q[push_idx].tail;
  assign pop_rd    = bus.oup_req_i & pop_hit;
  assign pop_eff   = pop_rd & bus.oup_pop_i;

`ifdef ID_QUEUE_DP_BYPASS_EN
  assign bypass_hit = bus.oup_req_i & push_gnt & ~pop_hit & (bus.inp_id_i == bus.oup_id_i);
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed pop consumes the pushed element, so it never reaches storage.
  assign push_store = push_gnt & ~(bypass_hit & bus.oup_pop_i);
  assign count_d    = count_q + CNT_W'(push_store) - CNT_W'(pop_eff);

  always_comb begin
    bus.oup_data_valid_o = 1'b0;
    bus.oup_data_o       = '0;
    if (pop_rd) begin
      bus.oup_data_valid_o = 1'b1;
      bus.oup_data_o       = ld_q[pop_head].data;
    end else if (bypass_hit) begin
      bus.oup_data_valid_o = 1'b1;
      bus.oup_data_o       = bus.inp_data_i;
    end
  end

  always_comb begin
    bus.exists_o = 1'b0;
    for (int i = 0; i < int'(CAPACITY); i++) begin
      if (bus.exists_req_i && !ld_q[i].free &&
          (((ld_q[i].data ^ bus.exists_data_i) & bus.exists_mask_i) == '0)) begin
        bus.exists_o = 1'b1;
      end
    end
  end

  // Pop is applied first so a same-ID push edits the post-pop entry.
  always_comb begin
    ht_d = ht_q;
    ld_d = ld_q;
    if (pop_eff) begin
      ld_d[pop_head].free = 1'b1;
      if (pop_head == ht_q[pop_idx].tail) ht_d[pop_idx].free = 1'b1;
      else                                ht_d[pop_idx].head = ld_q[pop_head].next;
    end
    if (push_store) begin
      ld_d[free_slot].data = bus.inp_data_i;
      ld_d[free_slot].next = '0;
      ld_d[free_slot].free = 1'b0;
      if (push_hit) begin
        ld_d[push_tail].next = free_slot;
        ht_d[push_idx].tail  = free_slot;
        // Same ID lost its only element to the pop: keep the entry and
        // restart it on the new slot rather than free and reallocate.
        if (pop_eff && (pop_idx == push_idx) && (pop_head == push_tail)) begin
          ht_d[push_idx].free = 1'b0;
          ht_d[push_idx].head = free_slot;
        end
      end else begin
        ht_d[free_ht] = '{id: bus.inp_id_i, head: free_slot, tail: free_slot, free: 1'b0};
      end
    end
  end

  // State register: reset touches only free flags and count, never payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int i = 0; i < int'(HT_CAPACITY); i++) ht_q[i].free <= 1'b1;
      for (int i = 0; i < int'(CAPACITY); i++)    ld_q[i].free <= 1'b1;
    end else begin
      count_q <= count_d;
      ht_q    <= ht_d;
      ld_q    <= ld_d;
    end
  end

endmodule

// File: tb/tb_id_queue_dp.sv
// tb_id_queue_dp
//   Directed bench for id_queue_dp. A per-ID queue model predicts pop/read
//   results, which are queued when stimulus is driven and compared when the
//   outputs are sampled. Honours ID_QUEUE_DP_BYPASS_EN when defined.
module tb_id_queue_dp;
  localparam int unsigned ID_W = 2;
  localparam int unsigned DW   = 8;
  localparam int unsigned CAP  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_queue_dp_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DW), .CAPACITY(CAP)) bus ();

  id_queue_dp #(.ID_WIDTH(ID_W), .CAPACITY(CAP), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mq [4][$];
  int         mcount = 0;
  logic [8:0] exp_q [$];

  logic       obs_valid, obs_gnt, obs_full, obs_empty, obs_exists;
  logic [7:0] obs_data;
  logic [3:0] obs_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag,
                      input bit preq, input logic [1:0] pid, input logic [7:0] pdata,
                      input bit oreq, input logic [1:0] oid, input bit opop,
                      input bit ereq, input logic [7:0] edata, input logic [7:0] emask);
    bit         full_m, push_g, byp, had, ex_m;
    logic [8:0] expd;
    @(negedge clk);
    bus.inp_req_i     = preq;  bus.inp_id_i = pid;  bus.inp_data_i = pdata;
    bus.oup_req_i     = oreq;  bus.oup_id_i = oid;  bus.oup_pop_i  = opop;
    bus.exists_req_i  = ereq;  bus.exists_data_i = edata;  bus.exists_mask_i = emask;
    full_m = (mcount == int'(CAP));
    push_g = preq && !full_m;
    had    = (mq[oid].size() > 0);
    byp    = 1'b0;
    expd   = '0;
    if (oreq && had) expd = {1'b1, mq[oid][0]};
`ifdef ID_QUEUE_DP_BYPASS_EN
    else if (oreq && push_g && (pid == oid)) begin
      expd = {1'b1, pdata};
      byp  = 1'b1;
    end
`endif
    exp_q.push_back(expd);
    ex_m = 1'b0;
    if (ereq) begin
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < mq[k].size(); j++)
          if (((mq[k][j] ^ edata) & emask) == 8'h00) ex_m = 1'b1;
    end
    #2;
    obs_valid  = bus.oup_data_valid_o;
    obs_data   = bus.oup_data_o;
    obs_gnt    = bus.inp_gnt_o;
    obs_full   = bus.full_o;
    obs_empty  = bus.empty_o;
    obs_exists = bus.exists_o;
    obs_count  = bus.count_o;
    chk({tag, "/oup"},    32'({obs_valid, obs_data}), 32'(exp_q.pop_front()));
    chk({tag, "/gnt"},    32'(obs_gnt),    32'(!full_m));
    chk({tag, "/count"},  32'(obs_count),  32'(mcount));
    chk({tag, "/full"},   32'(obs_full),   32'(full_m));
    chk({tag, "/empty"},  32'(obs_empty),  32'(mcount == 0));
    chk({tag, "/exists"}, 32'(obs_exists), 32'(ex_m));
    chk({tag, "/ognt"},   32'(bus.oup_gnt_o), 32'(oreq));
    if (oreq && opop && had) begin
      void'(mq[oid].pop_front());
      mcount--;
    end
    if (push_g && !(byp && opop)) begin
      mq[pid].push_back(pdata);
      mcount++;
    end
  endtask

  task automatic push(input string tag, input logic [1:0] id, input logic [7:0] d);
    step(tag, 1'b1, id, d, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask
  task automatic pop(input string tag, input logic [1:0] id);
    step(tag, 1'b0, 2'd0, 8'h00, 1'b1, id, 1'b1, 1'b0, 8'h00, 8'h00);
  endtask
  task automatic rd(input string tag, input logic [1:0] id);
    step(tag, 1'b0, 2'd0, 8'h00, 1'b1, id, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask
  task automatic ex(input string tag, input bit req, input logic [7:0] d, input logic [7:0] m);
    step(tag, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, req, d, m);
  endtask

  initial begin
    rst = 1'b1;
    bus.inp_req_i = 1'b0; bus.inp_id_i = '0; bus.inp_data_i = '0;
    bus.oup_req_i = 1'b0; bus.oup_id_i = '0; bus.oup_pop_i = 1'b0;
    bus.exists_req_i = 1'b0; bus.exists_data_i = '0; bus.exists_mask_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state; mask 0 would match anything, but nothing is stored.
    step("rst", 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("rst_empty", 32'(obs_empty), 32'd1);
    chk("rst_gnt", 32'(obs_gnt), 32'd1);
    chk("rst_valid", 32'(obs_valid), 32'd0);

    // Basic per-ID FIFO order.
    push("p_a1", 2'd1, 8'hA1);
    push("p_a2", 2'd1, 8'hA2);
    push("p_b1", 2'd2, 8'hB1);
    pop("pop1_a1", 2'd1);
    chk("pop1_a1_lit", 32'({obs_valid, obs_data}), 32'h1A1);
    chk("pop1_cnt3", 32'(obs_count), 32'd3);
    pop("pop1_a2", 2'd1);
    chk("pop1_a2_lit", 32'({obs_valid, obs_data}), 32'h1A2);
    rd("rd2_b1", 2'd2);
    chk("rd2_b1_lit", 32'({obs_valid, obs_data}), 32'h1B1);
    chk("rd2_cnt1", 32'(obs_count), 32'd1);

    // Fill to capacity, then push+pop while full.
    push("f0", 2'd0, 8'h01);
    push("f1", 2'd0, 8'h02);
    push("f2", 2'd3, 8'h31);
    push("f3", 2'd3, 8'h32);
    push("f4", 2'd1, 8'h11);
    push("f5", 2'd0, 8'h03);
    push("f6", 2'd2, 8'h21);
    step("full_pp", 1'b1, 2'd0, 8'h55, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("full_pp_gnt", 32'(obs_gnt), 32'd0);
    chk("full_pp_pop", 32'({obs_valid, obs_data}), 32'h101);
    push("after_full", 2'd0, 8'h55);
    chk("after_full_gnt", 32'(obs_gnt), 32'd1);
    chk("after_full_cnt", 32'(obs_count), 32'd7);
    rd("full_again", 2'd3);
    chk("full_again_full", 32'(obs_full), 32'd1);
    pop("drain0a", 2'd0);
    pop("drain0b", 2'd0);
    pop("drain0c", 2'd0);
    chk("drain0c_lit", 32'({obs_valid, obs_data}), 32'h155);

    // Reset with 5 held and a push pending in the reset cycle.
    @(negedge clk);
    rst = 1'b1;
    bus.inp_req_i = 1'b1; bus.inp_id_i = 2'd1; bus.inp_data_i = 8'hEE;
    bus.oup_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.inp_req_i = 1'b0;
    for (int k = 0; k < 4; k++) mq[k].delete();
    mcount = 0;
    for (int k = 0; k < 4; k++) begin
      rd("post_rst_rd", 2'(k));
      chk("post_rst_valid", 32'(obs_valid), 32'd0);
    end
    chk("post_rst_empty", 32'(obs_empty), 32'd1);

    // Same-ID push+pop on a single-element ID.
    push("p_33", 2'd3, 8'h33);
    step("pp3", 1'b1, 2'd3, 8'h44, 1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("pp3_lit", 32'({obs_valid, obs_data}), 32'h133);
    rd("rd3_44", 2'd3);
    chk("rd3_44_lit", 32'({obs_valid, obs_data}), 32'h144);
    chk("rd3_cnt1", 32'(obs_count), 32'd1);
    pop("pop3_44", 2'd3);

    // Pop/read of an absent ID with a concurrent push of that ID.
    step("byp_pop", 1'b1, 2'd2, 8'h77, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 8'h00);
`ifdef ID_QUEUE_DP_BYPASS_EN
    chk("byp_pop_lit", 32'({obs_valid, obs_data}), 32'h177);
    rd("byp_rd2", 2'd2);
    chk("byp_cnt", 32'(obs_count), 32'd0);
`else
    chk("byp_pop_lit", 32'({obs_valid, obs_data}), 32'h000);
    rd("byp_rd2", 2'd2);
    chk("byp_cnt", 32'(obs_count), 32'd1);
    chk("byp_rd2_lit", 32'({obs_valid, obs_data}), 32'h177);
`endif
    step("byp_read", 1'b1, 2'd1, 8'h66, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00);
    pop("byp_read_pop", 2'd1);
    chk("byp_read_pop_lit", 32'({obs_valid, obs_data}), 32'h166);

    // Exists search under mask.
    push("p_f0", 2'd0, 8'hF0);
    push("p_0f", 2'd1, 8'h0F);
    ex("ex_hi", 1'b1, 8'hFF, 8'hF0);
    chk("ex_hi_lit", 32'(obs_exists), 32'd1);
    ex("ex_zero", 1'b1, 8'h00, 8'hFF);
    chk("ex_zero_lit", 32'(obs_exists), 32'd0);
    ex("ex_noreq", 1'b0, 8'hFF, 8'h00);
    chk("ex_noreq_lit", 32'(obs_exists), 32'd0);
    ex("ex_freed", 1'b1, 8'h66, 8'hFF);
    ex("ex_mask0", 1'b1, 8'h00, 8'h00);
    chk("ex_mask0_lit", 32'(obs_exists), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
